load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 97 +++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: M-stage initiator turning loads/stores into valid/ready data-memory transactions
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] LoadDataM,
  output logic        LoadValidM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  state_t state, state_nx;
  logic        req, is_b, is_h, is_w, mis, start, hit, tmo;
  logic [31:0] addr_q, wdata_q, wdata_d, ext;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [15:0] cnt;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  assign req   = MemWriteM | MemReadM;
  assign is_w  = Funct3M[1];
  assign is_h  = Funct3M[1:0] == 2'b01;
  assign is_b  = Funct3M[1:0] == 2'b00;
  assign mis   = (is_h & ALUResultM[0]) | (is_w & |ALUResultM[1:0]);
  assign start = state == IDLE & req & !mis;
  assign hit   = state == RSP & mem_rsp_valid;
  // a response in the limit cycle takes precedence over the timeout
  assign tmo   = state == RSP & !mem_rsp_valid & (cnt == 16'(TIMEOUT_CYCLES - 1));
  assign wstrb_d = is_b ? 4'b0001 << ALUResultM[1:0] : is_h ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = is_b ? {4{WriteDataM[7:0]}} : is_h ? {2{WriteDataM[15:0]}} : WriteDataM;
  assign bsel = 8'(mem_rsp_rdata >> {addr_q[1:0], 3'b000});
  assign hsel = addr_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
  assign ext  = f3_q[1] ? mem_rsp_rdata :
                f3_q[0] ? {{16{~f3_q[2] & hsel[15]}}, hsel} : {{24{~f3_q[2] & bsel[7]}}, bsel};
  assign mem_req_valid = state == REQ;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  // gated by reset so the stall drops immediately even with a request still present
  assign StallM = rst & (start | state == REQ | state == RSP);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? REQ : IDLE;
      REQ:     state_nx = mem_req_ready ? RSP : REQ;
      RSP:     state_nx = (hit | tmo) ? DONE : RSP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      cnt        <= '0;
      LoadDataM  <= '0;
      LoadValidM <= 1'b0;
      MisalignM  <= 1'b0;
      BusErrM    <= 1'b0;
    end else begin
      state      <= state_nx;
      MisalignM  <= state == IDLE & req & mis;
      LoadValidM <= hit & !we_q;
      BusErrM    <= tmo;
      cnt        <= state == RSP ? cnt + 16'd1 : 16'd0;
      if (start) begin
        addr_q  <= ALUResultM;
        we_q    <= MemWriteM;
        f3_q    <= Funct3M;
        wdata_q <= wdata_d;
        wstrb_q <= MemWriteM ? wstrb_d : 4'b0000;
      end
      if (hit & !we_q) LoadDataM <= ext;
      else if (tmo) LoadDataM <= '0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with directed vectors
module tb_load_store_unit;
  logic        clk, rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, LoadValidM, MisalignM, BusErrM;
  logic [31:0] LoadDataM;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [3:0]  mem_req_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallM(StallM), .LoadDataM(LoadDataM),
    .LoadValidM(LoadValidM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int K_REQ = 0, K_LOAD = 1, K_MIS = 2, K_BERR = 3;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic take(input int k, input string name, output exp_t e, output bit ok);
    ok = sb.size() != 0 && sb[0].kind == k;
    if (ok) e = sb.pop_front();
    else begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (mem_req_valid && mem_req_ready) begin
      take(K_REQ, "req", e, ok);
      if (ok) begin
        check("req_addr", mem_req_addr, e.addr);
        check("req_we", 32'(mem_req_we), 32'(e.we));
        check("req_wstrb", 32'(mem_req_wstrb), 32'(e.wstrb));
        if (e.we) check("req_wdata", mem_req_wdata, e.wdata);
      end
    end
    if (LoadValidM) begin
      take(K_LOAD, "load_valid", e, ok);
      if (ok) check("load_data", LoadDataM, e.addr);
    end
    if (MisalignM) take(K_MIS, "misalign", e, ok);
    if (BusErrM) begin
      take(K_BERR, "bus_err", e, ok);
      if (ok) begin
        check("berr_data", LoadDataM, 32'h0);
        check("berr_valid", 32'(LoadValidM), 32'h0);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input int req_wait, input int rsp_wait, input logic [31:0] rdata,
                      input logic [31:0] exp_v, input logic [3:0] exp_strb, input string name);
    int st = 0;
    sb.push_back('{K_REQ, {addr[31:2], 2'b00}, exp_v, we ? exp_strb : 4'b0000, we});
    if (!we) sb.push_back('{K_LOAD, exp_v, 32'h0, 4'h0, 1'b0});
    MemWriteM = we; MemReadM = !we; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    #1 st += int'(StallM);
    step;
    for (int i = 0; i < req_wait; i++) begin
      #1 st += int'(StallM);
      step;
    end
    mem_req_ready = 1'b1;
    #1 st += int'(StallM);
    step;
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      #1 st += int'(StallM);
      step;
    end
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    #1 st += int'(StallM);
    step;
    mem_rsp_valid = 1'b0;
    #1 check({name, " done_stall"}, 32'(StallM), 32'h0);
    check({name, " stall_cycles"}, 32'(st), 32'(3 + req_wait + rsp_wait));
    step;
    MemWriteM = 1'b0; MemReadM = 1'b0;
  endtask

  task automatic misal(input bit we, input logic [2:0] f3, input logic [31:0] addr, input string name);
    sb.push_back('{K_MIS, 32'h0, 32'h0, 4'h0, 1'b0});
    MemWriteM = we; MemReadM = !we; Funct3M = f3; ALUResultM = addr; WriteDataM = 32'h55;
    #1 check({name, " stall"}, 32'(StallM), 32'h0);
    step;
    MemWriteM = 1'b0; MemReadM = 1'b0;
    #1 check({name, " req_valid"}, 32'(mem_req_valid), 32'h0);
    step;
    check({name, " idle_valid"}, 32'(mem_req_valid), 32'h0);
    step;
  endtask

  initial begin
    rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = '0; WriteDataM = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    #12;
    check("rst StallM", 32'(StallM), 32'h0);
    check("rst req_valid", 32'(mem_req_valid), 32'h0);
    check("rst pulses", {29'h0, LoadValidM, MisalignM, BusErrM}, 32'h0);
    check("rst LoadDataM", LoadDataM, 32'h0);
    step;
    rst = 1'b1;
    step;
    xact(1'b0, 3'b010, 32'h100, 32'h0, 2, 2, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, "lw");
    xact(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0, 32'hA5A5A5A5, 4'b1000, "sb");
    xact(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80011234, 32'hFFFF8001, 4'h0, "lh");
    xact(1'b0, 3'b101, 32'h102, 32'h0, 1, 0, 32'h80011234, 32'h00008001, 4'h0, "lhu");
    xact(1'b0, 3'b000, 32'h101, 32'h0, 0, 1, 32'h000080FF, 32'hFFFFFF80, 4'h0, "lb");
    xact(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'hAB000000, 32'h000000AB, 4'h0, "lbu");
    xact(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 32'h0, 32'hBEEFBEEF, 4'b1100, "sh");
    xact(1'b1, 3'b010, 32'h010, 32'h12345678, 1, 1, 32'h0, 32'h12345678, 4'b1111, "sw");
    xact(1'b0, 3'b111, 32'h020, 32'h0, 0, 0, 32'h89ABCDEF, 32'h89ABCDEF, 4'h0, "lw_f111");
    xact(1'b0, 3'b010, 32'h024, 32'h0, 0, 3, 32'h0BADF00D, 32'h0BADF00D, 4'h0, "rsp_at_limit");
    misal(1'b1, 3'b010, 32'h006, "mis_sw");
    misal(1'b0, 3'b001, 32'h101, "mis_lh");
    misal(1'b0, 3'b101, 32'h103, "mis_lhu");
    misal(1'b0, 3'b011, 32'h002, "mis_f011");
    sb.push_back('{K_REQ, 32'h300, 32'h0, 4'h0, 1'b0});
    sb.push_back('{K_BERR, 32'h0, 32'h0, 4'h0, 1'b0});
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
    step;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    step; step; step;
    check("tmo last_rsp_stall", 32'(StallM), 32'h1);
    step;
    check("tmo done_stall", 32'(StallM), 32'h0);
    check("tmo BusErrM", 32'(BusErrM), 32'h1);
    step;
    MemReadM = 1'b0;
    check("tmo BusErr_once", 32'(BusErrM), 32'h0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFFFFFF;
    step;
    mem_rsp_valid = 1'b0;
    step;
    check("tmo late_rsp_data", LoadDataM, 32'h0);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400;
    step;
    check("rst_mid valid_before", 32'(mem_req_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_mid StallM", 32'(StallM), 32'h0);
    MemReadM = 1'b0;
    step;
    rst = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11111111;
    step;
    mem_rsp_valid = 1'b0;
    check("rst_mid idle_valid", 32'(mem_req_valid), 32'h0);
    check("rst_mid idle_stall", 32'(StallM), 32'h0);
    step;
    xact(1'b0, 3'b010, 32'h404, 32'h0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'h0, "after_rst");
    step; step;
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
